seq_divider: RTL and testbench

//   Multi-cycle radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU ops.
//   The inverse of the DSP multiply/add/subtract path: one trial subtraction per cycle.

---
 rtl/seq_divider_if.sv | 23 ++
 rtl/seq_divider.sv | 107 ++++++++++
 tb/tb_seq_divider.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// Handshake and operand bus between the pipeline and the sequential divider.
// The pipeline is the master: it drives the request and captures result on done.
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, op, dividend, divisor,
        input  busy, done, result
    );

    modport slave (
        input  start, op, dividend, divisor,
        output busy, done, result
    );
endinterface

// File: rtl/seq_divider.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Signed ops divide magnitudes and fix the signs in a final FIX cycle.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    seq_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [CW-1:0]    count;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] quo, rem, dvs;
    logic             neg_q, neg_r;
    logic [WIDTH:0]   trial;
    logic             sgn_in;
    logic [WIDTH-1:0] q_fix, r_fix;

    assign sgn_in = ~bus.op[0];

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next = state;
        bus.busy   = 1'b0;
        trial      = {rem, quo[WIDTH-1]} - {1'b0, dvs};
        q_fix      = (~op_q[0] && neg_q) ? -quo : quo;
        r_fix      = (~op_q[0] && neg_r) ? -rem : rem;
        case (state)
            S_IDLE: if (bus.start) state_next = (bus.divisor == '0) ? S_FIX : S_CALC;
            S_CALC: begin
                bus.busy = 1'b1;
                if (count == LAST) state_next = S_FIX;
            end
            S_FIX: begin
                bus.busy   = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: all registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= '0;
            op_q       <= '0;
            quo        <= '0;
            rem        <= '0;
            dvs        <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            bus.done   <= 1'b0;
            bus.result <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                S_IDLE: if (bus.start) begin
                    op_q  <= bus.op;
                    count <= '0;
                    if (bus.divisor == '0) begin
                        // Divide by zero: quotient -1, remainder is the untouched dividend.
                        quo   <= '1;
                        rem   <= bus.dividend;
                        dvs   <= '0;
                        neg_q <= 1'b0;
                        neg_r <= 1'b0;
                    end else begin
                        quo   <= (sgn_in && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
                        dvs   <= (sgn_in && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;
                        rem   <= '0;
                        neg_q <= sgn_in && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                        neg_r <= sgn_in && bus.dividend[WIDTH-1];
                    end
                end
                S_CALC: begin
                    count <= count + CW'(1);
                    if (!trial[WIDTH]) begin
                        rem <= trial[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= {rem[WIDTH-2:0], quo[WIDTH-1]};
                        quo <= {quo[WIDTH-2:0], 1'b0};
                    end
                end
                S_FIX: begin
                    bus.result <= op_q[1] ? r_fix : q_fix;
                    bus.done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: the driver queues expected results from an
// arithmetic reference; a monitor checks value and latency on every done pulse.
`timescale 1ns/1ps
module tb_seq_divider;
  localparam int WIDTH = 32;

  typedef struct {
    logic [31:0] value;
    int          cyc;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_divider_if #(.WIDTH(WIDTH)) bus();
  seq_divider #(.WIDTH(WIDTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  function automatic logic [31:0] ref_result(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    case (op)
      2'b00:   return ovf ? a : 32'($signed(a) / $signed(b));
      2'b01:   return a / b;
      2'b10:   return ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default: return a % b;
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Caller sits on a negedge with the divider idle (or in its done cycle).
  task automatic issue(logic [1:0] op, logic [31:0] a, logic [31:0] b, string name);
    exp_t e;
    e.value = ref_result(op, a, b);
    e.cyc   = cyc + 1 + ((b == 0) ? 1 : WIDTH + 1);
    e.name  = name;
    exp_q.push_back(e);
    bus.start = 1'b1; bus.op = op; bus.dividend = a; bus.divisor = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op = 2'($urandom); bus.dividend = $urandom; bus.divisor = $urandom;
    check({name, " busy after accept"}, 32'(bus.busy), 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 100) begin @(negedge clk); n++; end
    if (bus.busy) check("idle timeout", 32'(bus.busy), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!reset && bus.done) begin
      if (exp_q.size() == 0) begin
        check("spurious done", 32'(bus.done), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check(mon_e.name, bus.result, mon_e.value);
        check({mon_e.name, " latency"}, 32'(cyc), 32'(mon_e.cyc));
        check({mon_e.name, " busy at done"}, 32'(bus.busy), 32'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, required < 1ms", $time);
    $fatal(1);
  end

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    int          n;
    reset = 1'b1;
    bus.start = 1'b0; bus.op = '0; bus.dividend = '0; bus.divisor = '0;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset result", bus.result, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    issue(2'b01, 32'd100, 32'd7, "divu 100/7");                 wait_idle();
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, "rem -7%2");             wait_idle();
    issue(2'b00, 32'hFFFF_FFF9, 32'd2, "div -7/2");             wait_idle();
    issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, "div ovf");      wait_idle();
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "rem ovf");      wait_idle();
    issue(2'b01, 32'd5, 32'd0, "divu 5/0");                     wait_idle();
    issue(2'b11, 32'd5, 32'd0, "remu 5/0");                     wait_idle();
    issue(2'b00, 32'hFFFF_FFFB, 32'd0, "div -5/0");             wait_idle();
    issue(2'b10, 32'hFFFF_FFFB, 32'd0, "rem -5/0");             wait_idle();
    issue(2'b10, 32'd7, 32'hFFFF_FFFE, "rem 7%-2");             wait_idle();

    // Abort mid-operation: nothing is queued, so any done pulse is flagged.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.dividend = 32'd100; bus.divisor = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort done", 32'(bus.done), 32'd0);
    check("abort result", bus.result, 32'd0);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    issue(2'b01, 32'd9, 32'd3, "divu 9/3 after abort");         wait_idle();

    // Start while busy is ignored; start in the done cycle is accepted.
    issue(2'b01, 32'd100, 32'd7, "divu 100/7 vs ignored start");
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b10; bus.dividend = 32'd1000; bus.divisor = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    issue(2'b01, 32'hDEAD_BEEF, 32'h0000_1234, "back-to-back divu");
    wait_idle();
    @(negedge clk);
    check("done pulse width", 32'(bus.done), 32'd0);

    for (int i = 0; i < 150; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2:       b = 32'($urandom_range(1, 15));
        3:       begin a = 32'($urandom_range(0, 40)) - 32'd20; b = 32'($urandom_range(0, 10)) - 32'd5; end
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
      wait_idle();
      issue(op, a, b, $sformatf("rand%0d op%0d %08h/%08h", i, op, a, b));
    end

    wait_idle();
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
